epp_host: RTL and testbench

- Initiator (host) end of the EPP parallel-port protocol.
- Drives the address strobe, data strobe, write strobe and data bus, and follows the peripheral's Wait handshake.
- Used to drive the board's EPP slave interface from on-chip logic, for loopback self-test and board-to-board links.
- Accepts one byte-wide command at a time over a valid/ready interface and returns a one-cycle response pulse.

---
 rtl/epp_host_if.sv | 31 +++
 rtl/epp_host.sv | 228 ++++++++++++++++++++++
 tb/tb_epp_host.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/epp_host_if.sv
// Command/response handshake and EPP bus signals of the epp_host block, bundled as one interface.
// The slave modport is the host engine; the master modport is whoever issues commands and acts as peripheral.
interface epp_host_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_is_addr;
    logic       cmd_write;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       astb_n;
    logic       dstb_n;
    logic       wr_n;
    logic [7:0] db_o;
    logic       db_oe;
    logic [7:0] db_i;
    logic       epp_wait;

    modport master (
        output cmd_valid, cmd_is_addr, cmd_write, cmd_data, db_i, epp_wait,
        input  cmd_ready, rsp_valid, rsp_data, rsp_timeout,
        input  astb_n, dstb_n, wr_n, db_o, db_oe
    );

    modport slave (
        input  cmd_valid, cmd_is_addr, cmd_write, cmd_data, db_i, epp_wait,
        output cmd_ready, rsp_valid, rsp_data, rsp_timeout,
        output astb_n, dstb_n, wr_n, db_o, db_oe
    );
endinterface

// File: rtl/epp_host.sv
// EPP host (initiator): runs one address/data read or write per accepted command.
// Optional macro EPP_HOST_TIMEOUT_EN aborts STROBE/RELEASE after TIMEOUT_CYCLES clocks.
module epp_host #(
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = 10
) (
    input  logic      clk,
    input  logic      rst,
    epp_host_if.slave epp_io
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StRelease,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] SetupLast = CNT_W'(SETUP_CYCLES - 1);
`ifdef EPP_HOST_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    if (SETUP_CYCLES < 1 || (32'd1 << CNT_W) <= SETUP_CYCLES ||
        (32'd1 << CNT_W) <= TIMEOUT_CYCLES) begin : g_param_check
        $error("epp_host: CNT_W too narrow or SETUP_CYCLES < 1");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wait_meta_q, wait_s_q;
    logic             is_addr_q, is_addr_d;
    logic             write_q, write_d;
    logic [7:0]       cap_q, cap_d;
    logic             astb_n_q, astb_n_d;
    logic             dstb_n_q, dstb_n_d;
    logic             wr_n_q, wr_n_d;
    logic [7:0]       db_o_q, db_o_d;
    logic             db_oe_q, db_oe_d;
    logic             ready_q;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
`ifdef EPP_HOST_TIMEOUT_EN
    logic             rsp_timeout_q, rsp_timeout_d;
`endif

    // Wait is asynchronous to clk; db_i is only sampled once wait_s is high, so it needs no sync.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_meta_q <= 1'b0;
            wait_s_q    <= 1'b0;
        end else begin
            wait_meta_q <= epp_io.epp_wait;
            wait_s_q    <= wait_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_addr_d   = is_addr_q;
        write_d     = write_q;
        cap_d       = cap_q;
        astb_n_d    = astb_n_q;
        dstb_n_d    = dstb_n_q;
        wr_n_d      = wr_n_q;
        db_o_d      = db_o_q;
        db_oe_d     = db_oe_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
`ifdef EPP_HOST_TIMEOUT_EN
        rsp_timeout_d = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (epp_io.cmd_valid && ready_q) begin
                    is_addr_d = epp_io.cmd_is_addr;
                    write_d   = epp_io.cmd_write;
                    wr_n_d    = ~epp_io.cmd_write;
                    if (epp_io.cmd_write) begin
                        db_o_d  = epp_io.cmd_data;
                        db_oe_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = StSetup;
                end
            end

            StSetup: begin
                if (cnt_q == SetupLast) begin
                    if (is_addr_q) begin
                        astb_n_d = 1'b0;
                    end else begin
                        dstb_n_d = 1'b0;
                    end
                    cnt_d   = '0;
                    state_d = StStrobe;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StStrobe: begin
                if (wait_s_q) begin
                    if (!write_q) begin
                        cap_d = epp_io.db_i;
                    end
                    astb_n_d = 1'b1;
                    dstb_n_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = StRelease;
                end
`ifdef EPP_HOST_TIMEOUT_EN
                else if (cnt_q == TimeoutLast) begin
                    astb_n_d      = 1'b1;
                    dstb_n_d      = 1'b1;
                    wr_n_d        = 1'b1;
                    db_oe_d       = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            StRelease: begin
                // Bus direction is held until the peripheral drops Wait.
                if (!wait_s_q) begin
                    wr_n_d      = 1'b1;
                    db_oe_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    if (!write_q) begin
                        rsp_data_d = cap_q;
                    end
                    state_d = StDone;
                end
`ifdef EPP_HOST_TIMEOUT_EN
                else if (cnt_q == TimeoutLast) begin
                    astb_n_d      = 1'b1;
                    dstb_n_d      = 1'b1;
                    wr_n_d        = 1'b1;
                    db_oe_d       = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            is_addr_q   <= 1'b0;
            write_q     <= 1'b0;
            cap_q       <= 8'h00;
            astb_n_q    <= 1'b1;
            dstb_n_q    <= 1'b1;
            wr_n_q      <= 1'b1;
            db_o_q      <= 8'h00;
            db_oe_q     <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_addr_q   <= is_addr_d;
            write_q     <= write_d;
            cap_q       <= cap_d;
            astb_n_q    <= astb_n_d;
            dstb_n_q    <= dstb_n_d;
            wr_n_q      <= wr_n_d;
            db_o_q      <= db_o_d;
            db_oe_q     <= db_oe_d;
            // Registered so it stays low during reset and rises on the first clk after release.
            ready_q     <= (state_d == StIdle);
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

`ifdef EPP_HOST_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign epp_io.rsp_timeout = rsp_timeout_q;
`else
    assign epp_io.rsp_timeout = 1'b0;
`endif

    assign epp_io.cmd_ready = ready_q;
    assign epp_io.rsp_valid = rsp_valid_q;
    assign epp_io.rsp_data  = rsp_data_q;
    assign epp_io.astb_n    = astb_n_q;
    assign epp_io.dstb_n    = dstb_n_q;
    assign epp_io.wr_n      = wr_n_q;
    assign epp_io.db_o      = db_o_q;
    assign epp_io.db_oe     = db_oe_q;

    a_one_strobe : assert property (@(posedge clk) disable iff (rst) (astb_n_q || dstb_n_q));
    a_rsp_pulse  : assert property (@(posedge clk) disable iff (rst) rsp_valid_q |=> !rsp_valid_q);

endmodule

// File: tb/tb_epp_host.sv
// Scoreboard bench for epp_host: directed commands against a behavioural EPP peripheral.
// Build with EPP_HOST_TIMEOUT_EN defined to exercise the abort path instead of the indefinite wait.
`timescale 1ns/1ps
module tb_epp_host;

    typedef struct packed {
        logic       timeout;
        logic [7:0] data;
    } rsp_t;

    typedef struct packed {
        logic       is_addr;
        logic       write;
        logic [7:0] data;
    } bus_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    epp_host_if bus ();

    epp_host #(
        .SETUP_CYCLES  (2),
        .TIMEOUT_CYCLES(20),
        .CNT_W         (10)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .epp_io(bus)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    rsp_t sb_q[$];
    bus_t bus_q[$];

    // Peripheral model state
    logic       resp_en     = 1'b1;
    int         resp_delay  = 3;
    logic       resp_wait   = 1'b0;
    logic       man_wait_en = 1'b0;
    logic       man_wait    = 1'b0;
    logic [7:0] addr_reg    = 8'h00;
    logic [7:0] data_reg    = 8'h00;

    assign bus.epp_wait = man_wait_en ? man_wait : resp_wait;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Response monitor: every rsp_valid pulse must match the oldest expected response.
    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            chk("strobe_excl", 32'(bus.astb_n | bus.dstb_n), 32'd1);
            if (bus.rsp_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.timeout));
                    chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                    // Ready returns with the abort pulse, but only after DONE on a normal finish.
                    chk("rsp_cmd_ready", 32'(bus.cmd_ready), 32'(e.timeout));
                end
            end
        end
    end

    // Responder: checks the bus for the whole strobe, then raises Wait after resp_delay cycles.
    initial begin : responder
        bus_t b;
        int   n;
        bus.db_i = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && (!bus.astb_n || !bus.dstb_n)) begin
                if (bus_q.size() == 0) begin
                    chk("strobe_unexpected", 32'd1, 32'd0);
                    b = '0;
                end else begin
                    b = bus_q.pop_front();
                end
                n = 0;
                while ((!bus.astb_n || !bus.dstb_n) && n < 200) begin
                    chk("astb_n", 32'(bus.astb_n), 32'(!b.is_addr));
                    chk("dstb_n", 32'(bus.dstb_n), 32'(b.is_addr));
                    chk("wr_n", 32'(bus.wr_n), 32'(!b.write));
                    chk("db_oe", 32'(bus.db_oe), 32'(b.write));
                    if (b.write) chk("db_o", 32'(bus.db_o), 32'(b.data));
                    if (resp_en && !man_wait_en && !resp_wait && n + 1 >= resp_delay) begin
                        if (!b.write) bus.db_i = b.is_addr ? addr_reg : data_reg;
                        else if (b.is_addr) addr_reg = b.data;
                        else data_reg = b.data;
                        resp_wait = 1'b1;
                    end
                    n++;
                    @(negedge clk);
                end
                if (n >= 200) chk("strobe_stuck", 32'd1, 32'd0);
                if (resp_wait) begin
                    @(negedge clk);
                    resp_wait = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic is_addr, input logic write, input logic [7:0] data,
                         input logic push, input logic exp_to, input logic [7:0] exp_data);
        bus_t b;
        rsp_t r;
        int   n = 0;
        b.is_addr = is_addr;
        b.write   = write;
        b.data    = data;
        bus_q.push_back(b);
        if (push) begin
            r.timeout = exp_to;
            r.data    = exp_data;
            sb_q.push_back(r);
        end
        @(negedge clk);
        bus.cmd_valid   = 1'b1;
        bus.cmd_is_addr = is_addr;
        bus.cmd_write   = write;
        bus.cmd_data    = data;
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("busy_after_accept", 32'(bus.cmd_ready), 32'd0);
    endtask

    task automatic release_cmd();
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_missing", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_dstb(input logic lvl, input string name);
        int n = 0;
        while (bus.dstb_n !== lvl && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(bus.dstb_n), 32'(lvl));
    endtask

    initial begin : stimulus
        int t0;
        int n;
        bus.cmd_valid   = 1'b0;
        bus.cmd_is_addr = 1'b0;
        bus.cmd_write   = 1'b0;
        bus.cmd_data    = 8'h00;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_astb_n", 32'(bus.astb_n), 32'd1);
        chk("rst_dstb_n", 32'(bus.dstb_n), 32'd1);
        chk("rst_wr_n", 32'(bus.wr_n), 32'd1);
        chk("rst_db_oe", 32'(bus.db_oe), 32'd0);
        chk("rst_db_o", 32'(bus.db_o), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

        // Address write 0x05, Wait 3 clks after strobe
        resp_delay = 3;
        issue(1'b1, 1'b1, 8'h05, 1'b1, 1'b0, 8'h00);
        release_cmd();
        drain();

        // Data read returning 0xA7, held afterwards
        data_reg = 8'hA7;
        issue(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA7);
        release_cmd();
        drain();
        repeat (3) @(negedge clk);
        chk("rsp_data_held", 32'(bus.rsp_data), 32'hA7);

        // Back-to-back with cmd_valid held high
        resp_delay = 1;
        issue(1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 8'hA7);
        issue(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 8'hA7);
        issue(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h3C);
        release_cmd();
        drain();
        issue(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h02);
        release_cmd();
        drain();

`ifdef EPP_HOST_TIMEOUT_EN
        // Silent peripheral: abort 20 clks after STROBE entry, rsp_data unchanged
        resp_en = 1'b0;
        issue(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h02);
        release_cmd();
        wait_dstb(1'b0, "to_strobe_low");
        t0 = cyc;
        n  = 0;
        while (bus.rsp_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency", 32'(cyc - t0), 32'd20);
        chk("to_strobe_released", 32'(bus.dstb_n), 32'd1);
        chk("to_db_oe", 32'(bus.db_oe), 32'd0);
        resp_en = 1'b1;
        drain();
`else
        // Silent peripheral: host must wait indefinitely
        resp_en = 1'b0;
        issue(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 8'h02);
        release_cmd();
        repeat (60) @(negedge clk);
        chk("hold_strobe", 32'(bus.dstb_n), 32'd0);
        chk("hold_pending", 32'(sb_q.size()), 32'd1);
        resp_en = 1'b1;
        drain();
        t0 = 0;
        n  = 0;
`endif

        // Wait already high when the command is accepted
        man_wait_en = 1'b1;
        man_wait    = 1'b1;
        repeat (4) @(negedge clk);
        issue(1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 8'h02);
        release_cmd();
        wait_dstb(1'b0, "early_wait_strobe_low");
        wait_dstb(1'b1, "early_wait_strobe_high");
        repeat (4) @(negedge clk);
        chk("early_wait_pending", 32'(sb_q.size()), 32'd1);
        man_wait = 1'b0;
        drain();
        man_wait_en = 1'b0;

        // Reset while in STROBE: abandon silently
        resp_en = 1'b0;
        issue(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        release_cmd();
        wait_dstb(1'b0, "rst_strobe_low");
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_dstb_n", 32'(bus.dstb_n), 32'd1);
        chk("mid_rst_astb_n", 32'(bus.astb_n), 32'd1);
        chk("mid_rst_db_oe", 32'(bus.db_oe), 32'd0);
        chk("mid_rst_wr_n", 32'(bus.wr_n), 32'd1);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus_q.delete();
        resp_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("post_rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        repeat (20) @(negedge clk);

        // Normal operation after reset
        issue(1'b1, 1'b1, 8'h9E, 1'b1, 1'b0, 8'h00);
        release_cmd();
        drain();
        chk("final_addr_reg", 32'(addr_reg), 32'h9E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
